// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: single-cycle core writeback has priority,
// long-latency results queue in a FIFO and drain into idle slots or by force.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_we,
  input  logic [4:0]  core_rd,
  input  logic [31:0] core_wd,
  input  logic [4:0]  core_rs1,
  input  logic [4:0]  core_rs2,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_wd,
  output logic        mc_ready,
  output logic        core_stall,
  output logic        pending_hit,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM  = SW'(STARVE_LIMIT);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [SW-1:0] r_starve;
  logic [4:0]    r_rd  [DEPTH];
  logic [31:0]   r_wd  [DEPTH];
  logic          r_vld [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_force;
  logic w_core_req;
  logic w_gnt_core;
  logic w_gnt_buf;
  logic w_enq;
  logic w_deq;
  logic w_hit;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL);
  assign w_force    = !w_empty && (r_starve == LIM);
  assign w_core_req = core_we && (core_rd != 5'd0);

  assign w_gnt_core = !w_force && w_core_req;
  assign w_gnt_buf  = !w_empty && !w_gnt_core;

  // x0 results complete the handshake but are never stored
  assign w_enq = mc_valid && !w_full && (mc_rd != 5'd0);
  assign w_deq = w_gnt_buf;

  assign mc_ready   = !w_full;
  assign core_stall = w_force;

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_rd[i] != 5'd0)) begin
        if ((r_rd[i] == core_rs1) ||
            (r_rd[i] == core_rs2) ||
            (core_we && (r_rd[i] == core_rd)))
          w_hit = 1'b1;
      end
    end
  end

  assign pending_hit = w_hit;

  always_comb begin
    WE3 = 1'b0;
    A3  = 5'd0;
    WD3 = 32'd0;
    if (!reset) begin
      unique case (1'b1)
        w_gnt_core: begin
          WE3 = 1'b1;
          A3  = core_rd;
          WD3 = core_wd;
        end
        w_gnt_buf: begin
          WE3 = 1'b1;
          A3  = r_rd[r_head];
          WD3 = r_wd[r_head];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]  <= 5'd0;
        r_wd[i]  <= 32'd0;
        r_vld[i] <= 1'b0;
      end
    end else begin
      if (w_enq) begin
        r_rd[r_tail]  <= mc_rd;
        r_wd[r_tail]  <= mc_wd;
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + AW'(1);
      end
      if (w_deq) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + AW'(1);
      end
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // head age: restarts for every new head and while nothing is queued
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_starve <= '0;
    else if (w_empty || w_gnt_buf)
      r_starve <= '0;
    else if (r_starve != LIM)
      r_starve <= r_starve + SW'(1);
  end

endmodule
